// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if
// Bundles the two requester ports and the memory-side bus of the
// memory arbiter.
//   slave  : arbiter view. Requests, memory read data and memory accept
//            come in. Per-port read data and acks, memory enables,
//            address, write data, grant and busy go out.
//   master : the opposite view, used by the requesters and memory together
//            (e.g. a testbench).
interface memory_arbiter_if;
    // requester port 0 (instruction fetch)
    logic        p0_req_i;
    logic        p0_wr_i;
    logic [31:0] p0_addr_i;
    logic [31:0] p0_data_i;
    logic [31:0] p0_data_o;
    logic        p0_ack_o;
    // requester port 1 (data load/store)
    logic        p1_req_i;
    logic        p1_wr_i;
    logic [31:0] p1_addr_i;
    logic [31:0] p1_data_i;
    logic [31:0] p1_data_o;
    logic        p1_ack_o;
    // memory side
    logic        mem_rd_en_o;
    logic        mem_wr_en_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;
    // status
    logic        grant_o;
    logic        busy_o;

    modport slave (
        input  p0_req_i, p0_wr_i, p0_addr_i, p0_data_i,
        input  p1_req_i, p1_wr_i, p1_addr_i, p1_data_i,
        input  mem_data_i, mem_ack_i,
        output p0_data_o, p0_ack_o, p1_data_o, p1_ack_o,
        output mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o,
        output grant_o, busy_o
    );

    modport master (
        output p0_req_i, p0_wr_i, p0_addr_i, p0_data_i,
        output p1_req_i, p1_wr_i, p1_addr_i, p1_data_i,
        output mem_data_i, mem_ack_i,
        input  p0_data_o, p0_ack_o, p1_data_o, p1_ack_o,
        input  mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o,
        input  grant_o, busy_o
    );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares one single-ported synchronous memory between two requesters.
// One request is latched at a time and issued to memory. Read data is
// captured the cycle after the accepted issue. A one-cycle ack then goes
// to the winning port.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : memory_arbiter_if.slave carrying both requester ports, the
//           memory bus, grant_o and busy_o
// Parameter:
//   ROUND_ROBIN : 1 = ties go to the port not granted last,
//                 0 = ties always go to port 0
module memory_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    memory_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic        grant_reg;
    logic        last_grant_reg;
    logic        wr_reg;
    logic [31:0] addr_reg;
    logic [31:0] data_reg;
    logic [31:0] p0_data_reg;
    logic [31:0] p1_data_reg;
    logic        p0_ack_reg;
    logic        p1_ack_reg;

    logic        any_req;
    logic        winner;
    logic        rd_en;
    logic        wr_en;

    assign any_req = bus.p0_req_i | bus.p1_req_i;

    // Winner selection, only meaningful while IDLE with a request pending.
    always_comb begin
        winner = 1'b0;
        if (bus.p1_req_i && !bus.p0_req_i) begin
            winner = 1'b1;
        end else if (bus.p1_req_i && bus.p0_req_i) begin
            winner = (ROUND_ROBIN != 0) ? ~last_grant_reg : 1'b0;
        end
    end

    // Next-state and memory enables.
    always_comb begin
        state_next = state_reg;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                rd_en = ~wr_reg;
                wr_en = wr_reg;
                // Memory back-pressure: hold the enables until accepted.
                if (bus.mem_ack_i) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next = DONE;
            end
            DONE: begin
                // Requests are deliberately ignored here so the requester
                // has one cycle to drop or renew after its ack.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Request latch, read-data capture and ack generation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            wr_reg         <= 1'b0;
            addr_reg       <= 32'd0;
            data_reg       <= 32'd0;
            p0_data_reg    <= 32'd0;
            p1_data_reg    <= 32'd0;
            p0_ack_reg     <= 1'b0;
            p1_ack_reg     <= 1'b0;
        end else begin
            p0_ack_reg <= 1'b0;
            p1_ack_reg <= 1'b0;

            if (state_reg == IDLE && any_req) begin
                grant_reg      <= winner;
                last_grant_reg <= winner;
                wr_reg         <= winner ? bus.p1_wr_i   : bus.p0_wr_i;
                addr_reg       <= winner ? bus.p1_addr_i : bus.p0_addr_i;
                data_reg       <= winner ? bus.p1_data_i : bus.p0_data_i;
            end

            if (state_reg == CAPTURE) begin
                if (grant_reg) begin
                    p1_ack_reg <= 1'b1;
                    if (!wr_reg) begin
                        p1_data_reg <= bus.mem_data_i;
                    end
                end else begin
                    p0_ack_reg <= 1'b1;
                    if (!wr_reg) begin
                        p0_data_reg <= bus.mem_data_i;
                    end
                end
            end
        end
    end

    assign bus.mem_rd_en_o = rd_en;
    assign bus.mem_wr_en_o = wr_en;
    // Address and write data come straight from the latch, so they hold
    // their last values outside ISSUE.
    assign bus.mem_addr_o  = addr_reg;
    assign bus.mem_data_o  = data_reg;
    assign bus.p0_data_o   = p0_data_reg;
    assign bus.p1_data_o   = p1_data_reg;
    assign bus.p0_ack_o    = p0_ack_reg;
    assign bus.p1_ack_o    = p1_ack_reg;
    assign bus.grant_o     = grant_reg;
    assign bus.busy_o      = (state_reg != IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
// Directed bench for memory_arbiter. One instance uses round-robin and one
// uses fixed priority. Each instance has a small synchronous memory model.
// Expected acks (port, cycle, read data) are queued when a request is
// driven. A per-instance monitor checks them as the acks appear.
module tb_memory_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    memory_arbiter_if rr_if ();
    memory_arbiter_if fx_if ();

    memory_arbiter #(.ROUND_ROBIN(1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(rr_if));
    memory_arbiter #(.ROUND_ROBIN(0)) u_fx (.clk(clk), .rst_n(rst_n), .bus(fx_if));

    typedef struct {
        logic        port;
        logic        chk_data;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb_rr[$];
    exp_t sb_fx[$];

    int total = 0;
    int bad   = 0;
    int rd_hi = 0;
    int wr_hi = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h1111_0000;
            1:       return 32'h2222_0004;
            8:       return 32'h1234_5678;
            9:       return 32'h9ABC_DEF0;
            default: return {16'hC0DE, 16'(i)};
        endcase
    endfunction

    // Memory models: word addressed, read data valid the cycle after rd_en.
    logic [31:0] mem_rr [64];
    logic [31:0] mem_fx [64];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem_rr[i] <= init_word(i);
        end else if (rr_if.mem_wr_en_o && rr_if.mem_ack_i) begin
            mem_rr[rr_if.mem_addr_o[7:2]] <= rr_if.mem_data_o;
        end
        if (rr_if.mem_rd_en_o) rr_if.mem_data_i <= mem_rr[rr_if.mem_addr_o[7:2]];
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem_fx[i] <= init_word(i);
        end else if (fx_if.mem_wr_en_o && fx_if.mem_ack_i) begin
            mem_fx[fx_if.mem_addr_o[7:2]] <= fx_if.mem_data_o;
        end
        if (fx_if.mem_rd_en_o) fx_if.mem_data_i <= mem_fx[fx_if.mem_addr_o[7:2]];
    end

    // Monitors: every ack must match the head of its scoreboard.
    always @(negedge clk) begin : mon_rr
        exp_t e;
        if (rst_n) begin
            if (rr_if.mem_rd_en_o) rd_hi++;
            if (rr_if.mem_wr_en_o) wr_hi++;
            if (rr_if.p0_ack_o || rr_if.p1_ack_o) begin
                if (sb_rr.size() == 0) begin
                    check("rr_spurious_ack", {30'b0, rr_if.p1_ack_o, rr_if.p0_ack_o}, 32'd0);
                end else begin
                    e = sb_rr.pop_front();
                    $display("rr ack: cyc=%0d p0=%b p1=%b d0=%08h d1=%08h", cyc,
                             rr_if.p0_ack_o, rr_if.p1_ack_o, rr_if.p0_data_o, rr_if.p1_data_o);
                    check("rr_ack_port", {30'b0, rr_if.p1_ack_o, rr_if.p0_ack_o},
                          e.port ? 32'd2 : 32'd1);
                    check("rr_ack_cycle", cyc, e.cyc);
                    if (e.chk_data)
                        check("rr_rdata", e.port ? rr_if.p1_data_o : rr_if.p0_data_o, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_fx
        exp_t e;
        if (rst_n && (fx_if.p0_ack_o || fx_if.p1_ack_o)) begin
            if (sb_fx.size() == 0) begin
                check("fx_spurious_ack", {30'b0, fx_if.p1_ack_o, fx_if.p0_ack_o}, 32'd0);
            end else begin
                e = sb_fx.pop_front();
                $display("fx ack: cyc=%0d p0=%b p1=%b d0=%08h d1=%08h", cyc,
                         fx_if.p0_ack_o, fx_if.p1_ack_o, fx_if.p0_data_o, fx_if.p1_data_o);
                check("fx_ack_port", {30'b0, fx_if.p1_ack_o, fx_if.p0_ack_o},
                      e.port ? 32'd2 : 32'd1);
                check("fx_ack_cycle", cyc, e.cyc);
                if (e.chk_data)
                    check("fx_rdata", e.port ? fx_if.p1_data_o : fx_if.p0_data_o, e.data);
            end
        end
    end

    function automatic exp_t mk(input logic port, input logic chk, input logic [31:0] d, input int c);
        exp_t e;
        e.port = port; e.chk_data = chk; e.data = d; e.cyc = c;
        return e;
    endfunction

    // One transaction on the round-robin instance, called at a negedge
    // with the arbiter idle. stall = ISSUE cycles with mem_ack_i low.
    task automatic run_rr(input logic port, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data, input int stall);
        logic got;
        if (port) begin
            rr_if.p1_req_i = 1'b1; rr_if.p1_wr_i = wr; rr_if.p1_addr_i = addr; rr_if.p1_data_i = wdata;
        end else begin
            rr_if.p0_req_i = 1'b1; rr_if.p0_wr_i = wr; rr_if.p0_addr_i = addr; rr_if.p0_data_i = wdata;
        end
        sb_rr.push_back(mk(port, ~wr, exp_data, cyc + 3 + stall));
        if (stall > 0) rr_if.mem_ack_i = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (k == stall) rr_if.mem_ack_i = 1'b1;
            got = port ? rr_if.p1_ack_o : rr_if.p0_ack_o;
        end
        rr_if.p0_req_i = 1'b0;
        rr_if.p1_req_i = 1'b0;
        check("rr_ack_seen", {31'b0, got}, 32'd1);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        int n_acks;
        logic got;

        rr_if.p0_req_i = 0; rr_if.p0_wr_i = 0; rr_if.p0_addr_i = 0; rr_if.p0_data_i = 0;
        rr_if.p1_req_i = 0; rr_if.p1_wr_i = 0; rr_if.p1_addr_i = 0; rr_if.p1_data_i = 0;
        rr_if.mem_ack_i = 1;
        fx_if.p0_req_i = 0; fx_if.p0_wr_i = 0; fx_if.p0_addr_i = 0; fx_if.p0_data_i = 0;
        fx_if.p1_req_i = 0; fx_if.p1_wr_i = 0; fx_if.p1_addr_i = 0; fx_if.p1_data_i = 0;
        fx_if.mem_ack_i = 1;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy",    {31'b0, rr_if.busy_o},      32'd0);
        check("rst_grant",   {31'b0, rr_if.grant_o},     32'd0);
        check("rst_rd_en",   {31'b0, rr_if.mem_rd_en_o}, 32'd0);
        check("rst_wr_en",   {31'b0, rr_if.mem_wr_en_o}, 32'd0);
        check("rst_acks",    {30'b0, rr_if.p1_ack_o, rr_if.p0_ack_o}, 32'd0);
        check("rst_addr",    rr_if.mem_addr_o, 32'd0);
        check("rst_p0_data", rr_if.p0_data_o,  32'd0);
        check("rst_p1_data", rr_if.p1_data_o,  32'd0);
        check("rst_fx_busy", {31'b0, fx_if.busy_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin tie from reset: p0, p1, p0, p1
        rr_if.p0_req_i = 1; rr_if.p0_addr_i = 32'h0;
        rr_if.p1_req_i = 1; rr_if.p1_addr_i = 32'h4;
        sb_rr.push_back(mk(1'b0, 1'b1, 32'h1111_0000, cyc + 3));
        sb_rr.push_back(mk(1'b1, 1'b1, 32'h2222_0004, cyc + 7));
        sb_rr.push_back(mk(1'b0, 1'b1, 32'h1111_0000, cyc + 11));
        sb_rr.push_back(mk(1'b1, 1'b1, 32'h2222_0004, cyc + 15));
        n_acks = 0;
        for (int k = 0; k < 40 && n_acks < 4; k++) begin
            @(negedge clk);
            if (rr_if.p0_ack_o || rr_if.p1_ack_o) n_acks++;
        end
        rr_if.p0_req_i = 0; rr_if.p1_req_i = 0;
        check("rr_tie_acks", n_acks, 32'd4);
        @(negedge clk);
        check("rr_tie_sb_empty", sb_rr.size(), 32'd0);

        // Fixed priority tie: three p0 acks, then p1 after p0 drops
        fx_if.p0_req_i = 1; fx_if.p0_addr_i = 32'h20;
        fx_if.p1_req_i = 1; fx_if.p1_addr_i = 32'h24;
        sb_fx.push_back(mk(1'b0, 1'b1, 32'h1234_5678, cyc + 3));
        sb_fx.push_back(mk(1'b0, 1'b1, 32'h1234_5678, cyc + 7));
        sb_fx.push_back(mk(1'b0, 1'b1, 32'h1234_5678, cyc + 11));
        sb_fx.push_back(mk(1'b1, 1'b1, 32'h9ABC_DEF0, cyc + 15));
        n_acks = 0;
        for (int k = 0; k < 40 && n_acks < 3; k++) begin
            @(negedge clk);
            if (fx_if.p0_ack_o) n_acks++;
        end
        fx_if.p0_req_i = 0;
        check("fx_p0_acks", n_acks, 32'd3);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = fx_if.p1_ack_o;
        end
        fx_if.p1_req_i = 0;
        check("fx_p1_ack_seen", {31'b0, got}, 32'd1);
        @(negedge clk);
        check("fx_sb_empty", sb_fx.size(), 32'd0);

        // Asynchronous reset in the middle of a p1 read's ISSUE cycle
        rr_if.p1_req_i = 1; rr_if.p1_wr_i = 0; rr_if.p1_addr_i = 32'h0;
        @(negedge clk);
        check("issue_rd_en", {31'b0, rr_if.mem_rd_en_o}, 32'd1);
        check("issue_grant", {31'b0, rr_if.grant_o},     32'd1);
        check("issue_busy",  {31'b0, rr_if.busy_o},      32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rd_en",  {31'b0, rr_if.mem_rd_en_o}, 32'd0);
        check("arst_wr_en",  {31'b0, rr_if.mem_wr_en_o}, 32'd0);
        check("arst_busy",   {31'b0, rr_if.busy_o},      32'd0);
        check("arst_grant",  {31'b0, rr_if.grant_o},     32'd0);
        check("arst_acks",   {30'b0, rr_if.p1_ack_o, rr_if.p0_ack_o}, 32'd0);
        rr_if.p1_req_i = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_p1_data", rr_if.p1_data_o, 32'd0);
        run_rr(1'b0, 1'b0, 32'h0, 32'h0, 32'h1111_0000, 0);

        // p0 writes 0x10, p1 reads it back
        base = wr_hi;
        run_rr(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 0);
        check("wr_en_cycles", wr_hi - base, 32'd1);
        run_rr(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
        check("p0_data_held", rr_if.p0_data_o, 32'h1111_0000);

        // Two stalled ISSUE cycles on a p1 read
        base = rd_hi;
        run_rr(1'b1, 1'b0, 32'h20, 32'h0, 32'h1234_5678, 2);
        check("stall_rd_cycles", rd_hi - base, 32'd3);

        // p0 changes its address during ISSUE; the latched address is used
        rr_if.p0_req_i = 1; rr_if.p0_wr_i = 0; rr_if.p0_addr_i = 32'h20;
        sb_rr.push_back(mk(1'b0, 1'b1, 32'h1234_5678, cyc + 3));
        @(negedge clk);
        rr_if.p0_addr_i = 32'h24;
        check("fc_mem_addr", rr_if.mem_addr_o, 32'h20);
        check("fc_rd_en", {31'b0, rr_if.mem_rd_en_o}, 32'd1);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = rr_if.p0_ack_o;
        end
        rr_if.p0_req_i = 0;
        check("fc_ack_seen", {31'b0, got}, 32'd1);
        check("fc_p1_data_held", rr_if.p1_data_o, 32'h1234_5678);
        @(negedge clk);

        check("rr_sb_final", sb_rr.size(), 32'd0);
        check("fx_sb_final", sb_fx.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
